// File: rtl/neural_layer_engine.sv
// neural_layer_engine: sequences 1..MAX_LAYERS square fully-connected layers.
// Each layer fetches one weight word per input index from external RAM with a
// one-cycle read latency. Every unit multiply-accumulates, then its result is
// shifted, saturated and optionally rectified. The result becomes the unit's
// input for the next layer.
module neural_layer_engine #(
    parameter int NUM_UNITS  = 4,
    parameter int DATA_W     = 32,
    parameter int WEIGHT_W   = 8,
    parameter int FRAC_BITS  = 0,
    parameter int MAX_LAYERS = 4,
    parameter int AW         = (MAX_LAYERS * NUM_UNITS > 1) ? $clog2(MAX_LAYERS * NUM_UNITS) : 1,
    parameter int LC_W       = $clog2(MAX_LAYERS) + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [LC_W-1:0]               layer_cnt,
    input  logic                          relu_en,
    input  logic [NUM_UNITS*DATA_W-1:0]   in_data,
    output logic                          weight_rd,
    output logic [AW-1:0]                 weight_addr,
    input  logic [NUM_UNITS*WEIGHT_W-1:0] weight_data,
    output logic [NUM_UNITS*DATA_W-1:0]   out_data,
    output logic                          busy,
    output logic                          done,
    output logic                          ovf
);

    localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int ACC_W = DATA_W + WEIGHT_W + $clog2(NUM_UNITS);

    // Saturation bounds expressed at accumulator width
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WB    = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Activation: shift, saturate, rectify. Bit DATA_W flags a clamp.
    function automatic logic [DATA_W:0] act_f(input logic signed [ACC_W-1:0] x,
                                              input logic                    relu);
        logic signed [ACC_W-1:0] y;
        logic [DATA_W-1:0]       v;
        logic                    clamp;
        y = x >>> FRAC_BITS;
        if (y > SAT_MAX) begin
            v     = SAT_MAX[DATA_W-1:0];
            clamp = 1'b1;
        end else if (y < SAT_MIN) begin
            v     = SAT_MIN[DATA_W-1:0];
            clamp = 1'b1;
        end else begin
            v     = y[DATA_W-1:0];
            clamp = 1'b0;
        end
        if (relu && v[DATA_W-1]) begin
            v = '0;
        end else begin
            v = v;
        end
        return {clamp, v};
    endfunction

    // Weight RAM address for a (layer, input index) pair
    function automatic logic [AW-1:0] addr_f(input logic [LC_W-1:0]  l,
                                             input logic [IDX_W-1:0] i);
        return AW'(32'(l) * 32'(NUM_UNITS) + 32'(i));
    endfunction

    state_t                  state_r, state_nxt_s;
    logic [LC_W-1:0]         layer_r, layer_nxt_s;
    logic [IDX_W-1:0]        idx_r, idx_nxt_s;
    logic [LC_W-1:0]         lcnt_r, lc_eff_s;
    logic                    relu_r;
    logic                    accept_s, wb_s, last_s;

    logic                    weight_rd_r, busy_r, done_r, ovf_r;
    logic [AW-1:0]           weight_addr_r;
    logic [IDX_W-1:0]        idx_rd_r, idx_d_r;
    logic                    valid_r;
    logic [NUM_UNITS*DATA_W-1:0] out_data_r;

    logic signed [DATA_W-1:0] data_r [NUM_UNITS];
    logic signed [ACC_W-1:0]  acc_r  [NUM_UNITS];
    logic signed [ACC_W-1:0]  prod_s [NUM_UNITS];
    logic [DATA_W:0]          act_s  [NUM_UNITS];
    logic signed [DATA_W-1:0] data_sel_s;
    logic                     clamp_any_s;

    // Effective layer count: zero runs one layer, large values clamp
    always_comb begin
        lc_eff_s = layer_cnt;
        if (layer_cnt == '0) begin
            lc_eff_s = LC_W'(1);
        end else if (layer_cnt > LC_W'(MAX_LAYERS)) begin
            lc_eff_s = LC_W'(MAX_LAYERS);
        end else begin
            lc_eff_s = layer_cnt;
        end
    end

    // Next-state and sequencing decisions
    always_comb begin
        state_nxt_s = state_r;
        layer_nxt_s = layer_r;
        idx_nxt_s   = idx_r;
        accept_s    = 1'b0;
        wb_s        = 1'b0;
        last_s      = (layer_r == (lcnt_r - LC_W'(1)));
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_RUN;
                    layer_nxt_s = '0;
                    idx_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (idx_r == IDX_W'(NUM_UNITS - 1)) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    idx_nxt_s = idx_r + IDX_W'(1);
                end
            end
            ST_DRAIN: begin
                state_nxt_s = ST_WB;
            end
            ST_WB: begin
                wb_s = 1'b1;
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    layer_nxt_s = layer_r + LC_W'(1);
                    idx_nxt_s   = '0;
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register plus control outputs registered from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            layer_r       <= '0;
            idx_r         <= '0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            weight_rd_r   <= 1'b0;
            weight_addr_r <= '0;
            idx_rd_r      <= '0;
        end else begin
            state_r     <= state_nxt_s;
            layer_r     <= layer_nxt_s;
            idx_r       <= idx_nxt_s;
            busy_r      <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN) ||
                           (state_nxt_s == ST_WB);
            done_r      <= (state_nxt_s == ST_DONE);
            weight_rd_r <= (state_nxt_s == ST_RUN);
            if (state_nxt_s == ST_RUN) begin
                weight_addr_r <= addr_f(layer_nxt_s, idx_nxt_s);
                idx_rd_r      <= idx_nxt_s;
            end else begin
                weight_addr_r <= weight_addr_r;
                idx_rd_r      <= idx_rd_r;
            end
        end
    end

    // Per-unit products and activations for the current accumulator values
    always_comb begin
        data_sel_s  = data_r[idx_d_r];
        clamp_any_s = 1'b0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            prod_s[u]   = ACC_W'(data_sel_s) *
                          ACC_W'($signed(weight_data[u*WEIGHT_W +: WEIGHT_W]));
            act_s[u]    = act_f(acc_r[u], relu_r);
            clamp_any_s = clamp_any_s | act_s[u][DATA_W];
        end
    end

    // Datapath: operand capture, MAC, write-back and result/flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r    <= 1'b0;
            idx_d_r    <= '0;
            lcnt_r     <= LC_W'(1);
            relu_r     <= 1'b0;
            ovf_r      <= 1'b0;
            out_data_r <= '0;
            for (int u = 0; u < NUM_UNITS; u++) begin
                data_r[u] <= '0;
                acc_r[u]  <= '0;
            end
        end else begin
            valid_r <= weight_rd_r;
            idx_d_r <= idx_rd_r;
            if (accept_s) begin
                lcnt_r <= lc_eff_s;
                relu_r <= relu_en;
                ovf_r  <= 1'b0;
                for (int u = 0; u < NUM_UNITS; u++) begin
                    data_r[u] <= in_data[u*DATA_W +: DATA_W];
                    acc_r[u]  <= '0;
                end
            end else if (wb_s) begin
                ovf_r <= ovf_r | clamp_any_s;
                for (int u = 0; u < NUM_UNITS; u++) begin
                    data_r[u] <= act_s[u][DATA_W-1:0];
                    acc_r[u]  <= '0;
                    if (last_s) begin
                        out_data_r[u*DATA_W +: DATA_W] <= act_s[u][DATA_W-1:0];
                    end else begin
                        out_data_r[u*DATA_W +: DATA_W] <= out_data_r[u*DATA_W +: DATA_W];
                    end
                end
            end else if (valid_r) begin
                for (int u = 0; u < NUM_UNITS; u++) begin
                    acc_r[u] <= acc_r[u] + prod_s[u];
                end
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    assign weight_rd   = weight_rd_r;
    assign weight_addr = weight_addr_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign ovf         = ovf_r;
    assign out_data    = out_data_r;

endmodule

// File: tb/tb_neural_layer_engine.sv
// Scoreboard bench for neural_layer_engine: stimulus pushes expected read
// addresses and expected run results; a negedge monitor pops and compares.
module tb_neural_layer_engine;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int WW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [2:0]        layer_cnt;
    logic              relu_en;
    logic [N*DW-1:0]   in_data;
    logic              weight_rd;
    logic [3:0]        weight_addr;
    logic [N*WW-1:0]   weight_data;
    logic [N*DW-1:0]   out_data;
    logic              busy, done, ovf;

    neural_layer_engine dut (
        .clk(clk), .reset(reset), .start(start), .layer_cnt(layer_cnt),
        .relu_en(relu_en), .in_data(in_data), .weight_rd(weight_rd),
        .weight_addr(weight_addr), .weight_data(weight_data),
        .out_data(out_data), .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*DW-1:0] out;
        logic            ovf;
        time             t_acc;
        int              lat;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] addr_q[$];
    logic [N*WW-1:0] wmem [16];
    int   total = 0;
    int   bad   = 0;
    logic addr_chk = 1'b1;

    // Weight RAM with one-cycle read latency
    always @(posedge clk) begin
        if (weight_rd) weight_data <= wmem[weight_addr];
    end

    task automatic chk(input string name, input logic [N*DW-1:0] got, input logic [N*DW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic logic [N*DW-1:0] pk(input int a, input int b, input int c, input int d);
        return {32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction

    function automatic logic [N*WW-1:0] wpk(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    // Monitor: address stream and run results against the scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (weight_rd && addr_chk) begin
                if (addr_q.size() == 0) begin
                    chk("unexpected_read", 128'(weight_addr), 128'hFFFF);
                end else begin
                    chk("weight_addr", 128'(weight_addr), 128'(addr_q.pop_front()));
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 128'(done), 128'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.out);
                    chk("ovf", 128'(ovf), 128'(e.ovf));
                    chk("latency", 128'(($time - e.t_acc - 5) / 10), 128'(e.lat));
                    chk("busy_at_done", 128'(busy), 128'(0));
                end
            end else if (exp_q.size() > 0 && $time > exp_q[0].t_acc + 64'(exp_q[0].lat * 10 + 5)) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_timeout", 128'(0), 128'(1));
            end
        end
    end

    // Present a run request, queue its expectations, return after acceptance
    task automatic issue(input logic [2:0] lc, input logic r, input logic [N*DW-1:0] d,
                         input logic [N*DW-1:0] eo, input logic eovf, input int L);
        exp_t e;
        @(negedge clk);
        start = 1'b1; layer_cnt = lc; relu_en = r; in_data = d;
        for (int l = 0; l < L; l++)
            for (int i = 0; i < N; i++) addr_q.push_back(4'(l * N + i));
        @(posedge clk);
        e.out = eo; e.ovf = eovf; e.t_acc = $time; e.lat = L * (N + 2);
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", 128'(busy), 128'(1));
    endtask

    task automatic run(input logic [2:0] lc, input logic r, input logic [N*DW-1:0] d,
                       input logic [N*DW-1:0] eo, input logic eovf, input int L);
        issue(lc, r, d, eo, eovf, L);
        repeat (L * (N + 2) + 2) @(negedge clk);
    endtask

    task automatic load_w(input int kind);
        for (int a = 0; a < 16; a++) begin
            case (kind)
                0:       wmem[a] = wpk((a % 4) == 0 ? 1 : 0, (a % 4) == 1 ? 1 : 0,
                                       (a % 4) == 2 ? 1 : 0, (a % 4) == 3 ? 1 : 0);
                1:       wmem[a] = wpk(2, 2, 2, 2);
                default: wmem[a] = wpk(127, 127, 127, 127);
            endcase
        end
    endtask

    initial begin
        exp_t e;
        time  t1;
        reset = 1'b1; start = 1'b0; layer_cnt = 3'd0; relu_en = 1'b0;
        in_data = '0; weight_data = '0;
        load_w(0);
        #1;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_ovf", 128'(ovf), 128'(0));
        chk("rst_rd", 128'(weight_rd), 128'(0));
        chk("rst_addr", 128'(weight_addr), 128'(0));
        chk("rst_out", out_data, 128'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Identity weights, plain and rectified
        run(3'd1, 1'b0, pk(5, -3, 7, 0), pk(5, -3, 7, 0), 1'b0, 1);
        issue(3'd1, 1'b1, pk(5, -3, 7, 0), pk(5, 0, 7, 0), 1'b0, 1);
        repeat (2) @(negedge clk);
        start = 1'b1; layer_cnt = 3'd3; relu_en = 1'b0; in_data = pk(9, 9, 9, 9);
        @(negedge clk);
        start = 1'b0;
        repeat (N + 4) @(negedge clk);
        // layer_cnt of zero runs a single layer
        run(3'd0, 1'b0, pk(5, -3, 7, 0), pk(5, -3, 7, 0), 1'b0, 1);

        // Two layers of all-2 weights
        load_w(1);
        run(3'd2, 1'b0, pk(1, 1, 1, 1), pk(64, 64, 64, 64), 1'b0, 2);

        // Saturation in both directions
        load_w(2);
        run(3'd1, 1'b0, {4{32'h7FFFFFFF}}, {4{32'h7FFFFFFF}}, 1'b1, 1);
        run(3'd1, 1'b0, {4{32'h80000001}}, {4{32'h80000000}}, 1'b1, 1);

        // Abort a two-layer run during layer 1
        addr_chk = 1'b0;
        @(negedge clk);
        start = 1'b1; layer_cnt = 3'd2; relu_en = 1'b0; in_data = {4{32'h7FFFFFFF}};
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("rd_before_rst", 128'(weight_rd), 128'(1));
        chk("ovf_before_rst", 128'(ovf), 128'(1));
        reset = 1'b1;
        #1;
        chk("arst_busy", 128'(busy), 128'(0));
        chk("arst_done", 128'(done), 128'(0));
        chk("arst_ovf", 128'(ovf), 128'(0));
        chk("arst_rd", 128'(weight_rd), 128'(0));
        chk("arst_out", out_data, 128'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        addr_chk = 1'b1;
        load_w(0);
        run(3'd1, 1'b0, pk(5, -3, 7, 0), pk(5, -3, 7, 0), 1'b0, 1);

        // start held through DONE: second run with no idle gap
        @(negedge clk);
        start = 1'b1; layer_cnt = 3'd1; relu_en = 1'b0; in_data = pk(5, -3, 7, 0);
        for (int k = 0; k < 2 * N; k++) addr_q.push_back(4'(k % N));
        @(posedge clk);
        t1 = $time;
        e.out = pk(5, -3, 7, 0); e.ovf = 1'b0; e.t_acc = t1; e.lat = N + 2;
        exp_q.push_back(e);
        e.out = pk(1, 2, 3, 4); e.t_acc = t1 + 64'((N + 3) * 10);
        exp_q.push_back(e);
        repeat (N + 3) @(negedge clk);
        in_data = pk(1, 2, 3, 4);
        @(negedge clk);
        start = 1'b0;
        repeat (N + 6) @(negedge clk);

        chk("exp_q_drained", 128'(exp_q.size()), 128'(0));
        chk("addr_q_drained", 128'(addr_q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
